serial_subtractor: RTL and testbench

- Multi-cycle, bit-serial N-bit two's-complement subtractor: res = a - b - b_in, one bit per clock, LSB first, with a single borrow flip-flop.
- Inverse datapath of the ripple-carry adder; it shares the flag semantics (borrow-out, signed overflow) and is used where area matters more than latency.
- start/busy/done handshake to the issuing controller.

---
 rtl/serial_sub_pkg.sv | 31 +++
 rtl/sub_bit_cell.sv | 28 ++
 rtl/serial_subtractor.sv | 179 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor:
//     - state_t     : controller state encoding (IDLE / RUN / DONE)
//     - sat_min_pat : most-negative two's-complement pattern of width n
//     - sat_max_pat : most-positive two's-complement pattern of width n
//   The saturation helpers return a wide vector. Callers truncate the result
//   to their own width with a size cast. Only the low n bits are meaningful.
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned SAT_PAT_W = 256;
  localparam logic [SAT_PAT_W-1:0] SAT_ONE = {{(SAT_PAT_W-1){1'b0}}, 1'b1};

  // {1'b1, {n-1{1'b0}}}
  function automatic logic [SAT_PAT_W-1:0] sat_min_pat(input int unsigned n);
    return SAT_ONE << (n - 1);
  endfunction

  // {1'b0, {n-1{1'b1}}}
  function automatic logic [SAT_PAT_W-1:0] sat_max_pat(input int unsigned n);
    return (SAT_ONE << (n - 1)) - SAT_ONE;
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// -----------------------------------------------------------------------------
// sub_bit_cell
//   Combinational 1-bit full subtractor: computes a - b - bor_in.
//   Ports:
//     i_a     minuend bit
//     i_b     subtrahend bit
//     i_bor   borrow in
//     o_d     difference bit
//     o_bor   borrow out
// -----------------------------------------------------------------------------
module sub_bit_cell
  import serial_sub_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bor,
  output logic o_d,
  output logic o_bor
);

  logic w_axb;

  assign w_axb = i_a ^ i_b;
  assign o_d   = w_axb ^ i_bor;
  // Borrow when a=0,b=1, or when the bits are equal and a borrow ripples in.
  assign o_bor = (~i_a & i_b) | (~w_axb & i_bor);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit two's-complement subtractor: res = a - b - b_in.
//   One bit is processed per clock, LSB first, through a single sub_bit_cell
//   with one borrow flip-flop. The N-bit latency trades speed for area.
//
//   Configuration macro: SERIAL_SUB_SAT_EN
//     defined   -> on signed overflow the latched res is clamped to the
//                  most-negative (a[N-1]=1) or most-positive (a[N-1]=0) value.
//                  b_out and overflow still report the raw flags.
//     undefined -> res is the wrapped modulo-2^N difference.
//
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-high reset
//     start     request, sampled only when not busy (IDLE or DONE)
//     a, b      minuend / subtrahend, captured on an accepted start
//     b_in      borrow-in, captured on an accepted start
//     busy      high for the N RUN cycles
//     done      one-cycle pulse. res/b_out/overflow are valid from here on.
//     res       difference (held until the next completion)
//     b_out     borrow out of the MSB (unsigned a < b + b_in)
//     overflow  signed overflow
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] res,
  output logic         b_out,
  output logic         overflow
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_a_sh;
  logic [N-1:0]   r_b_sh;
  logic [N-1:0]   r_res_sh;
  logic           r_bor;
  logic [N-1:0]   r_res;
  logic           r_b_out;
  logic           r_ovf;

  logic           w_accept;
  logic           w_last;
  logic           w_d;
  logic           w_bor;
  logic           w_ovf;
  logic [N-1:0]   w_res_full;
  logic [N-1:0]   w_res_final;

  // The single arithmetic cell always looks at the LSBs of the working regs.
  sub_bit_cell u_cell (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_bor (r_bor),
    .o_d   (w_d),
    .o_bor (w_bor)
  );

  assign w_last = (r_state == S_RUN) && (r_cnt == LAST_BIT);

  // The result assembled on the final edge includes the bit being produced now.
  assign w_res_full = {w_d, r_res_sh[N-1:1]};

  // On the last bit, r_bor is the borrow into the MSB and w_bor the borrow out.
  assign w_ovf = r_bor ^ w_bor;

`ifdef SERIAL_SUB_SAT_EN
  localparam logic [N-1:0] SAT_MIN = N'(sat_min_pat(N));
  localparam logic [N-1:0] SAT_MAX = N'(sat_max_pat(N));

  // On the last bit, r_a_sh[0] is the sign bit of the captured minuend.
  always_comb begin
    w_res_final = w_res_full;
    if (w_ovf) begin
      w_res_final = r_a_sh[0] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign w_res_final = w_res_full;
`endif

  // Controller: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Controller: next state and handshake outputs
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, serial shifting and result latching.
  // Visible outputs change only on the final RUN edge. Working regs absorb
  // all intermediate activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_bor    <= 1'b0;
      r_res    <= '0;
      r_b_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_bor    <= b_in;
      r_res_sh <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_full;
      r_bor    <= w_bor;
      if (w_last) begin
        r_cnt   <= '0;
        r_res   <= w_res_final;
        r_b_out <= w_bor;
        r_ovf   <= w_ovf;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign res      = r_res;
  assign b_out    = r_b_out;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] res;
  logic         b_out;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .b_out    (b_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic void ref_sub(input logic [7:0] ia, input logic [7:0] ib,
                                  input logic ibin, output logic [7:0] r,
                                  output logic bo, output logic ov);
    int ud;
    int sd;
    ud = int'(ia) - int'(ib) - int'(ibin);
    sd = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
    bo = (ud < 0);
    ov = (sd < -128) || (sd > 127);
    r  = ud[7:0];
`ifdef SERIAL_SUB_SAT_EN
    if (ov) r = ia[7] ? 8'h80 : 8'h7F;
`endif
  endfunction

  // Drive a one-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; b_in = ibin;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
  endtask

  // Bounded wait for done; reports cycles waited and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    #12;
    n_vec++;
    if ({busy, done, res, b_out, overflow} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 000", {busy, done, res, b_out, overflow});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({busy, done, res} !== 10'h000) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h want 000", {busy, done, res});
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
    logic [7:0] tb [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
`ifdef SERIAL_SUB_SAT_EN
    logic [7:0] er [4] = '{8'h02, 8'hFE, 8'h80, 8'h7F};
`else
    logic [7:0] er [4] = '{8'h02, 8'hFE, 8'h7F, 8'h80};
`endif
    logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int cyc, bcnt;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], 1'b0);
      wait_done(cyc, bcnt);
      n_vec++;
      if (cyc != N || bcnt != N) begin
        n_err++;
        $display("FAIL dir_latency[%0d]: got cyc=%0d busy=%0d want %0d", i, cyc, bcnt, N);
      end
      n_vec++;
      if (res !== er[i] || b_out !== eb[i] || overflow !== eo[i]) begin
        n_err++;
        $display("FAIL dir_result[%0d]: got res=%h bo=%b ov=%b want res=%h bo=%b ov=%b",
                 i, res, b_out, overflow, er[i], eb[i], eo[i]);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL dir_done_pulse[%0d]: got done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    issue(8'h00, 8'h00, 1'b1);
    wait_done(cyc, bcnt);
    n_vec++;
    if (res !== 8'hFF || b_out !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got res=%h bo=%b ov=%b want res=ff bo=1 ov=0", res, b_out, overflow);
    end
    // Still in the DONE cycle: issue the next operation immediately.
    start = 1'b1; a = 8'h10; b = 8'h01; b_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    wait_done(cyc, bcnt);
    n_vec++;
    if (cyc + 1 != N + 1) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d want %0d", cyc + 1, N + 1);
    end
    n_vec++;
    if (res !== 8'h0F || b_out !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got res=%h bo=%b ov=%b want res=0f bo=0 ov=0", res, b_out, overflow);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bcnt;
    issue(8'h20, 8'h01, 1'b0);
    @(negedge clk); @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h00; b_in = 1'b0;
    n_vec++;
    if (res !== 8'h0F) begin
      n_err++;
      $display("FAIL hold_during_run: got %h want 0f", res);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    n_vec++;
    if (cyc + 3 != N) begin
      n_err++;
      $display("FAIL ignore_latency: got %0d want %0d", cyc + 3, N);
    end
    n_vec++;
    if (res !== 8'h1F) begin
      n_err++;
      $display("FAIL ignore_result: got %h want 1f", res);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_no_queue: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [7:0] ia, ib, er;
    logic ibin, eb, eo;
    int cyc, bcnt;
    for (int i = 0; i < 40; i++) begin
      ia   = 8'($urandom);
      ib   = 8'($urandom);
      ibin = 1'($urandom);
      if (i == 0) begin ia = 8'h80; ib = 8'h00; ibin = 1'b1; end
      if (i == 1) begin ia = 8'h7F; ib = 8'h80; ibin = 1'b0; end
      ref_sub(ia, ib, ibin, er, eb, eo);
      issue(ia, ib, ibin);
      wait_done(cyc, bcnt);
      n_vec++;
      if (cyc != N) begin
        n_err++;
        $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, cyc, N);
      end
      n_vec++;
      if (res !== er || b_out !== eb || overflow !== eo) begin
        n_err++;
        $display("FAIL rnd_result[%0d] a=%h b=%h bin=%b: got res=%h bo=%b ov=%b want res=%h bo=%b ov=%b",
                 i, ia, ib, ibin, res, b_out, overflow, er, eb, eo);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcnt;
    bit saw_done;
    issue(8'h05, 8'h03, 1'b0);
    wait_done(cyc, bcnt);
    issue(8'h33, 8'h11, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, res, b_out, overflow} !== 12'h000) begin
      n_err++;
      $display("FAIL mid_run_reset: got %h want 000", {busy, done, res, b_out, overflow});
    end
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_err++;
      $display("FAIL abort_no_done: got activity after reset, want none");
    end
    issue(8'h10, 8'h01, 1'b0);
    wait_done(cyc, bcnt);
    n_vec++;
    if (cyc != N || res !== 8'h0F) begin
      n_err++;
      $display("FAIL recover: got cyc=%0d res=%h want cyc=%0d res=0f", cyc, res, N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
